// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Brief   : Shared debounce state encoding and default debounce length.
// Rev     : 1.0
// ============================================================================
package button_pkg;

    // 10 ms of stable samples at 50 MHz
    localparam int c_DB_TICKS_DEF = 500000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/db_channel.sv
`default_nettype none
// ============================================================================
// Module  : db_channel
// Brief   : One pushbutton channel: 2-flop synchronizer, debounce FSM/counter,
//           registered level and a one-cycle-early press indication.
// Rev     : 1.0
// ============================================================================
module db_channel
    import button_pkg::*;
#(
    parameter int DB_TICKS = c_DB_TICKS_DEF,
    parameter int CNT_W    = $clog2(DB_TICKS + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_fire
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DB_TICKS - 1);

    logic [1:0]       r_sync;
    logic             w_sync;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;

    assign w_sync  = r_sync[1];
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
        end
    end

    // Counter defaults to zero, so it clears on WAIT entry and in STABLE states.
    // o_fire marks the WAIT_HI->STABLE_HI edge; the parent registers it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        o_fire      = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sync) w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (!w_sync) begin
                    w_state_nxt = STABLE_LO;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = STABLE_HI;
                    o_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!w_sync) w_state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_sync) begin
                    w_state_nxt = STABLE_HI;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = STABLE_LO;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = STABLE_LO;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/button_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : button_pulse_gen
// Brief   : Debounces set/reset pushbuttons into registered one-cycle strobes
//           for a downstream SR flip-flop; reset wins on a simultaneous press.
// Rev     : 1.0
// ============================================================================
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int DB_TICKS = c_DB_TICKS_DEF,
    parameter int CNT_W    = $clog2(DB_TICKS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic s_btn,
    input  logic r_btn,
    output logic s_pulse,
    output logic r_pulse,
    output logic s_level,
    output logic r_level
);

    logic w_s_fire;
    logic w_r_fire;
    logic r_s_pulse;
    logic r_r_pulse;

    db_channel #(
        .DB_TICKS (DB_TICKS),
        .CNT_W    (CNT_W)
    ) u_s_chan (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (s_btn),
        .o_level (s_level),
        .o_fire  (w_s_fire)
    );

    db_channel #(
        .DB_TICKS (DB_TICKS),
        .CNT_W    (CNT_W)
    ) u_r_chan (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (r_btn),
        .o_level (r_level),
        .o_fire  (w_r_fire)
    );

    // A coincident set is dropped, not deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_pulse <= 1'b0;
            r_r_pulse <= 1'b0;
        end else begin
            r_s_pulse <= w_s_fire & ~w_r_fire;
            r_r_pulse <= w_r_fire;
        end
    end

    assign s_pulse = r_s_pulse;
    assign r_pulse = r_r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_pulse_gen
// Brief   : Directed self-checking bench for button_pulse_gen with DB_TICKS=4.
// Rev     : 1.0
// ============================================================================
module tb_button_pulse_gen;

    localparam int c_DB = 4;

    logic clk = 1'b0;
    logic reset;
    logic s_btn;
    logic r_btn;
    logic s_pulse;
    logic r_pulse;
    logic s_level;
    logic r_level;

    int n_checks = 0;
    int n_pass   = 0;

    button_pulse_gen #(
        .DB_TICKS (c_DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_btn   (s_btn),
        .r_btn   (r_btn),
        .s_pulse (s_pulse),
        .r_pulse (r_pulse),
        .s_level (s_level),
        .r_level (r_level)
    );

    always #5 clk = ~clk;

    // Outputs packed as {s_pulse, r_pulse, s_level, r_level}
    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (sp rp sl rl) at %0t", tag, act, exp, $time);
    endtask

    // Advance past one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {s_pulse, r_pulse, s_level, r_level};
    endfunction

    initial begin
        logic [8:0] bounce;
        bounce = 9'b111111011;  // bit i driven before edge i: 1,1,0,1,1,1,1,1,1

        reset = 1'b1;
        s_btn = 1'b0;
        r_btn = 1'b0;
        tick();
        tick();
        chk("reset_state", outs(), 4'b0000);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle_%0d", i), outs(), 4'b0000);
        end

        // Clean press: pulse in cycle after edge 6, held with no repeat
        s_btn = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("press_%0d", i), outs(), {(i == 6), 1'b0, (i >= 6), 1'b0});
        end

        // Release: level falls after edge 6, no pulses
        s_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("release_%0d", i), outs(), {1'b0, 1'b0, (i < 6), 1'b0});
        end

        // Bounce: the glitch restarts debounce, pulse after edge 9
        for (int i = 0; i < 16; i++) begin
            s_btn = (i < 9) ? bounce[i] : 1'b1;
            tick();
            chk($sformatf("bounce_%0d", i), outs(), {(i == 9), 1'b0, (i >= 9), 1'b0});
        end
        s_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bounce_released", outs(), 4'b0000);

        // Simultaneous press: reset strobe wins, set strobe suppressed
        s_btn = 1'b1;
        r_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("simul_%0d", i), outs(), {1'b0, (i == 6), (i >= 6), (i >= 6)});
        end
        s_btn = 1'b0;
        r_btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("simul_released", outs(), 4'b0000);

        // Reset mid-debounce: pulse 6 edges after the first post-reset edge
        r_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("prerst_%0d", i), outs(), 4'b0000);
        end
        reset = 1'b1;
        tick();
        chk("midrst", outs(), 4'b0000);
        reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk($sformatf("postrst_%0d", j), outs(), {1'b0, (j == 6), 1'b0, (j >= 6)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
